dsp_fetch: RTL
==============

DSP_FETCH -- requirements
Module: dsp_fetch

Interface
REQ-001 Shared constants: INST_WORD_LEN = 32, the FLOW_* codes (FLOW_NONE, FLOW_JMP, FLOW_BEZ, FLOW_BNEZ, FLOW_BEQ) and PC_RESET = 16'h0000 SHALL come from the shared definitions file.
REQ-002 Ports SHALL be, in order:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  instruction-memory read request.
- imem_addr  out  16  word address of the request.
- imem_ack  in  1  read data valid this cycle (same cycle as req or later).
- imem_rdata  in  32  instruction word, valid when imem_ack=1.
- stall  in  1  decode stage cannot accept a new instruction this cycle.
- redirect_valid  in  1  resolved flow-control result present this cycle.
- flow_mode  in  3  flow code of the resolving instruction.
- branch_taken  in  1  condition result for FLOW_BEZ/BNEZ/BEQ.
- jaddress  in  16  target PC.
- instruction  out  32  word presented to decode.
- inst_valid  out  1  instruction holds a live word; decode SHALL ignore it when 0.
- pc_out  out  16  address of the presented instruction.

Function
REQ-003 States SHALL be IDLE, REQ, HOLD and FLUSH; encoding is local.
REQ-004 IDLE: imem_req=0; SHALL go to REQ on the next edge.
REQ-005 REQ: imem_req=1 and imem_addr=pc; req and addr SHALL stay stable until imem_ack.
REQ-006 The word is consumed when stall=0 or inst_valid=0. On imem_ack with the word consumed and no redirect: instruction<=imem_rdata, pc_out<=pc, inst_valid<=1, pc<=pc+1, stay in REQ.
REQ-007 On imem_ack while stall=1 and inst_valid=1: imem_rdata and pc SHALL be captured into a one-entry skid register, pc<=pc+1, go to HOLD.
REQ-008 HOLD: imem_req=0. When stall=0, the skid contents SHALL move to instruction/pc_out with inst_valid=1, then go to REQ.
REQ-009 A taken redirect is redirect_valid=1 and (flow_mode=FLOW_JMP, or flow_mode in {FLOW_BEZ, FLOW_BNEZ, FLOW_BEQ} with branch_taken=1). redirect_valid with a not-taken branch or FLOW_NONE SHALL have no effect.
REQ-010 On a taken redirect, in any state: pc<=jaddress, inst_valid<=0 and the skid is emptied.
- If in REQ with no imem_ack that cycle, go to FLUSH.
- Otherwise, go to REQ; any same-cycle ack data SHALL be discarded.
REQ-011 FLUSH: imem_req=1 with the old address held. The ack data SHALL be discarded, then go to REQ at the new pc.
REQ-012 A redirect SHALL take priority over stall and imem_ack. A second redirect during FLUSH SHALL overwrite the pending pc.
REQ-013 pc arithmetic is 16-bit modulo: 16'hFFFF+1 = 16'h0000.
REQ-014 Latency: with zero-wait memory and stall=0, the first word fetched after reset SHALL appear with inst_valid=1 two edges after rst_n deassertion, then one word per cycle.
REQ-015 While stall=1, instruction, pc_out and inst_valid SHALL hold unless a redirect occurs.

Reset
REQ-016 On rst_n=0 (asynchronous): state=IDLE, pc=PC_RESET, instruction=32'h0, pc_out=16'h0, inst_valid=0, skid empty, imem_req=0.
REQ-017 Reset asserted mid-transaction SHALL abandon the outstanding request. A late imem_ack after reset SHALL be ignored, because the block is not in REQ or FLUSH.

Structure
REQ-018 The FLOW_* codes, INST_WORD_LEN and PC_RESET SHALL live in the shared definitions file, and the state encoding SHALL stay local.
REQ-019 The skid register SHALL be a sub-module, fetch_skid (data, pc, full flag, load/unload/clear).

Verification
REQ-020 Reset release with zero-wait memory returning word=addr+32'h1000 and stall=0 -> instruction 32'h1000, 32'h1001, 32'h1002 on consecutive cycles; pc_out 0, 1, 2.
REQ-021 Stall high for 3 cycles while the word at addr 5 is presented -> instruction holds the word for addr 5; the addr-6 word sits in skid with imem_req=0; after release, addr 6 then 7 follow with no gap or duplicate.
REQ-022 FLOW_JMP redirect with jaddress=16'h0040 while imem_ack is delayed 2 cycles -> FLUSH; stale data dropped; next valid instruction comes from pc_out=16'h0040.
REQ-023 FLOW_BEQ with branch_taken=0 -> no effect; same with branch_taken=1 and jaddress=16'h0010 -> inst_valid=0 for one cycle, then pc_out=16'h0010.
REQ-024 pc preset to 16'hFFFF by a jump -> the next fetch after 16'hFFFF is address 16'h0000.
REQ-025 rst_n pulsed low during FLUSH, with an ack arriving during reset -> outputs at reset values, ack ignored, fetch restarts at 16'h0000.

Source files
------------

// File: rtl/dsp_fetch_pkg.sv
// dsp_fetch_pkg: constants, types and flow-code helper shared by the fetch stage.
package dsp_fetch_pkg;
   localparam int INST_WORD_LEN = 32;
   localparam logic [2:0] FLOW_NONE = 3'd0;
   localparam logic [2:0] FLOW_JMP  = 3'd1;
   localparam logic [2:0] FLOW_BEZ  = 3'd2;
   localparam logic [2:0] FLOW_BNEZ = 3'd3;
   localparam logic [2:0] FLOW_BEQ  = 3'd4;
   localparam logic [15:0] PC_RESET = 16'h0000;
   typedef logic [15:0] pc_t;
   typedef logic [INST_WORD_LEN-1:0] word_t;
   function automatic logic flow_taken(input logic [2:0] mode, input logic taken);
      return mode == FLOW_JMP || (taken && (mode == FLOW_BEZ || mode == FLOW_BNEZ || mode == FLOW_BEQ));
   endfunction
endpackage

// File: rtl/dsp_fetch_skid.sv
// fetch_skid: one-entry holding register for a word fetched while decode is stalled.
module fetch_skid
   import dsp_fetch_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     load,
   input  logic                     unload,
   input  logic                     clear,
   input  logic [INST_WORD_LEN-1:0] d_data,
   input  logic [15:0]              d_pc,
   output logic [INST_WORD_LEN-1:0] q_data,
   output logic [15:0]              q_pc,
   output logic                     full
);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_data <= '0;
         q_pc   <= '0;
         full   <= 1'b0;
      end else begin
         if (load) begin
            q_data <= d_data;
            q_pc   <= d_pc;
         end
         full <= clear ? 1'b0 : load ? 1'b1 : unload ? 1'b0 : full;
      end
   end
endmodule

// File: rtl/dsp_fetch.sv
// dsp_fetch: instruction fetch stage with stall skid buffer and redirect flush handling.
module dsp_fetch
   import dsp_fetch_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst_n,
   output logic                     imem_req,
   output logic [15:0]              imem_addr,
   input  logic                     imem_ack,
   input  logic [INST_WORD_LEN-1:0] imem_rdata,
   input  logic                     stall,
   input  logic                     redirect_valid,
   input  logic [2:0]               flow_mode,
   input  logic                     branch_taken,
   input  logic [15:0]              jaddress,
   output logic [INST_WORD_LEN-1:0] instruction,
   output logic                     inst_valid,
   output logic [15:0]              pc_out
);
   localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, HOLD = 2'd2, FLUSH = 2'd3;
   logic [1:0] state;
   logic [15:0] pc, flush_addr, skid_pc;
   logic [INST_WORD_LEN-1:0] skid_data;
   logic redir, consumed, skid_load, skid_unload, skid_full;
   assign redir = redirect_valid && flow_taken(flow_mode, branch_taken);
   assign consumed = !stall || !inst_valid;
   assign imem_req = state == REQ || state == FLUSH;
   assign imem_addr = state == FLUSH ? flush_addr : pc;
   assign skid_load = !redir && state == REQ && imem_ack && !consumed;
   assign skid_unload = !redir && state == HOLD && !stall;
   fetch_skid u_skid (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (skid_load),
      .unload (skid_unload),
      .clear  (redir),
      .d_data (imem_rdata),
      .d_pc   (pc),
      .q_data (skid_data),
      .q_pc   (skid_pc),
      .full   (skid_full)
   );
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         pc          <= PC_RESET;
         flush_addr  <= PC_RESET;
         instruction <= '0;
         pc_out      <= '0;
         inst_valid  <= 1'b0;
      end else if (redir) begin
         // an outstanding request must still drain its ack before the new pc is used
         pc         <= jaddress;
         inst_valid <= 1'b0;
         flush_addr <= imem_addr;
         state      <= (imem_req && !imem_ack) ? FLUSH : REQ;
      end else begin
         case (state)
            IDLE: state <= REQ;
            REQ: begin
               if (imem_ack) begin
                  pc <= pc + 16'd1;
                  if (consumed) begin
                     instruction <= imem_rdata;
                     pc_out      <= pc;
                     inst_valid  <= 1'b1;
                  end else begin
                     state <= HOLD;
                  end
               end else if (!stall) begin
                  inst_valid <= 1'b0;
               end
            end
            HOLD: begin
               if (!stall) begin
                  instruction <= skid_data;
                  pc_out      <= skid_pc;
                  inst_valid  <= skid_full;
                  state       <= REQ;
               end
            end
            FLUSH: if (imem_ack) state <= REQ;
            default: state <= IDLE;
         endcase
      end
   end
endmodule
